fp_wrb_arbiter: RTL and testbench



---
 rtl/fp_wrb_pkg.sv | 23 ++
 rtl/wrb_src_fifo.sv | 48 ++++
 rtl/fp_wrb_arbiter.sv | 146 ++++++++++++++
 tb/tb_fp_wrb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wrb_pkg.sv
// Shared types and constants for the FP writeback arbiter: source indices and the buffered entry.
package fp_wrb_pkg;

    localparam int unsigned NUM_WRB_SRC  = 4;
    localparam int unsigned NUM_WR_PORTS = 2;
    localparam int unsigned SRC_IDX_W    = $clog2(NUM_WRB_SRC);

    typedef logic [SRC_IDX_W-1:0] src_idx_t;

    localparam src_idx_t SRC_FALU1    = src_idx_t'(0);
    localparam src_idx_t SRC_FALU2    = src_idx_t'(1);
    localparam src_idx_t SRC_LSU      = src_idx_t'(2);
    localparam src_idx_t SRC_FDIVSQRT = src_idx_t'(3);

    localparam int unsigned WRB_ADDR_W = 6;
    localparam int unsigned WRB_DATA_W = 64;

    typedef struct packed {
        logic [WRB_ADDR_W-1:0] address;
        logic [WRB_DATA_W-1:0] data;
    } wrb_entry_t;

endpackage

// File: rtl/wrb_src_fifo.sv
// Per-source result FIFO; occupancy-based full/empty flags come straight from registers.
module wrb_src_fifo
    import fp_wrb_pkg::*;
#(
    parameter type         entry_t = wrb_entry_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t entry,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: head is only consumed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fp_wrb_arbiter.sv
// FP regfile writeback arbiter: four buffered sources, two write ports, round-robin grant.
// Optional FP_WRB_STALL_CNT_EN adds a saturating count of cycles with more than two sources pending.
module fp_wrb_arbiter
    import fp_wrb_pkg::*;
#(
    parameter int unsigned REG_SIZE_WIDTH = 6,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned BUF_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      falu1_wrb_valid_i,
    input  logic                      falu1_wrb_float_i,
    input  logic [REG_SIZE_WIDTH-1:0] falu1_wrb_address_i,
    input  logic [DATA_WIDTH-1:0]     falu1_wrb_data_i,
    output logic                      falu1_wrb_ready_o,
    input  logic                      falu2_wrb_valid_i,
    input  logic                      falu2_wrb_float_i,
    input  logic [REG_SIZE_WIDTH-1:0] falu2_wrb_address_i,
    input  logic [DATA_WIDTH-1:0]     falu2_wrb_data_i,
    output logic                      falu2_wrb_ready_o,
    input  logic                      lsu_wrb_valid_i,
    input  logic                      lsu_wrb_float_i,
    input  logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_i,
    input  logic [DATA_WIDTH-1:0]     lsu_wrb_data_i,
    output logic                      lsu_wrb_ready_o,
    input  logic                      fdivsqrt_wrb_valid_i,
    input  logic [REG_SIZE_WIDTH-1:0] fdivsqrt_wrb_address_i,
    input  logic [DATA_WIDTH-1:0]     fdivsqrt_wrb_data_i,
    output logic                      fdivsqrt_wrb_ready_o,
    output logic                      wr_first_valid_o,
    output logic [REG_SIZE_WIDTH-1:0] wr_first_address_o,
    output logic [DATA_WIDTH-1:0]     wr_first_data_o,
    output logic                      wr_second_valid_o,
    output logic [REG_SIZE_WIDTH-1:0] wr_second_address_o,
    output logic [DATA_WIDTH-1:0]     wr_second_data_o
`ifdef FP_WRB_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    typedef struct packed {
        logic [REG_SIZE_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    logic [NUM_WRB_SRC-1:0] in_valid;
    logic [NUM_WRB_SRC-1:0] in_float;
    logic [NUM_WRB_SRC-1:0] push;
    logic [NUM_WRB_SRC-1:0] pop;
    logic [NUM_WRB_SRC-1:0] empty;
    logic [NUM_WRB_SRC-1:0] full;
    entry_t                 in_entry [NUM_WRB_SRC];
    entry_t                 head     [NUM_WRB_SRC];

    src_idx_t rr_ptr;
    src_idx_t scan_idx;
    src_idx_t g0_idx;
    src_idx_t g1_idx;
    logic     g0_valid;
    logic     g1_valid;

    assign in_valid = {fdivsqrt_wrb_valid_i, lsu_wrb_valid_i, falu2_wrb_valid_i, falu1_wrb_valid_i};
    assign in_float = {1'b1, lsu_wrb_float_i, falu2_wrb_float_i, falu1_wrb_float_i};

    assign in_entry[SRC_FALU1]    = '{address: falu1_wrb_address_i,    data: falu1_wrb_data_i};
    assign in_entry[SRC_FALU2]    = '{address: falu2_wrb_address_i,    data: falu2_wrb_data_i};
    assign in_entry[SRC_LSU]      = '{address: lsu_wrb_address_i,      data: lsu_wrb_data_i};
    assign in_entry[SRC_FDIVSQRT] = '{address: fdivsqrt_wrb_address_i, data: fdivsqrt_wrb_data_i};

    assign falu1_wrb_ready_o    = ~full[SRC_FALU1];
    assign falu2_wrb_ready_o    = ~full[SRC_FALU2];
    assign lsu_wrb_ready_o      = ~full[SRC_LSU];
    assign fdivsqrt_wrb_ready_o = ~full[SRC_FDIVSQRT];

    for (genvar s = 0; s < NUM_WRB_SRC; s++) begin : g_src
        // Integer results and writes to p0 complete the handshake but are dropped here.
        assign push[s] = in_valid[s] & ~full[s] & in_float[s] & (in_entry[s].address != '0);

        wrb_src_fifo #(
            .entry_t (entry_t),
            .DEPTH   (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[s]),
            .entry (in_entry[s]),
            .pop   (pop[s]),
            .head  (head[s]),
            .empty (empty[s]),
            .full  (full[s])
        );
    end

    always_comb begin
        g0_valid = 1'b0;
        g0_idx   = '0;
        g1_valid = 1'b0;
        g1_idx   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_WRB_SRC; k++) begin
            scan_idx = rr_ptr + src_idx_t'(k);
            if (!empty[scan_idx]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = scan_idx;
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (g0_valid) pop[g0_idx] = 1'b1;
        if (g1_valid) pop[g1_idx] = 1'b1;
    end

    assign wr_first_valid_o    = g0_valid;
    assign wr_first_address_o  = g0_valid ? head[g0_idx].address : '0;
    assign wr_first_data_o     = g0_valid ? head[g0_idx].data    : '0;
    assign wr_second_valid_o   = g1_valid;
    assign wr_second_address_o = g1_valid ? head[g1_idx].address : '0;
    assign wr_second_data_o    = g1_valid ? head[g1_idx].data    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rr_ptr <= '0;
        else if (g1_valid) rr_ptr <= g1_idx + src_idx_t'(1);
        else if (g0_valid) rr_ptr <= g0_idx + src_idx_t'(1);
    end

`ifdef FP_WRB_STALL_CNT_EN
    logic overload;

    assign overload = ($countones(~empty) > NUM_WR_PORTS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                stall_cnt_o <= '0;
        else if (overload && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// Scoreboard bench for fp_wrb_arbiter: queue-based reference model predicts each cycle's write ports and readies.
module tb_fp_wrb_arbiter;
    import fp_wrb_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int NS    = NUM_WRB_SRC;

    logic          clk;
    logic          rst_n;
    logic          v [NS];
    logic          f [NS];
    logic [AW-1:0] a [NS];
    logic [DW-1:0] d [NS];
    logic [NS-1:0] rdy;
    logic          w0_v, w1_v;
    logic [AW-1:0] w0_a, w1_a;
    logic [DW-1:0] w0_d, w1_d;
`ifdef FP_WRB_STALL_CNT_EN
    logic [31:0]   stall_cnt;
    longint        stall_model;
`endif

    fp_wrb_arbiter #(
        .REG_SIZE_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .BUF_DEPTH      (DEPTH)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .falu1_wrb_valid_i      (v[0]),
        .falu1_wrb_float_i      (f[0]),
        .falu1_wrb_address_i    (a[0]),
        .falu1_wrb_data_i       (d[0]),
        .falu1_wrb_ready_o      (rdy[0]),
        .falu2_wrb_valid_i      (v[1]),
        .falu2_wrb_float_i      (f[1]),
        .falu2_wrb_address_i    (a[1]),
        .falu2_wrb_data_i       (d[1]),
        .falu2_wrb_ready_o      (rdy[1]),
        .lsu_wrb_valid_i        (v[2]),
        .lsu_wrb_float_i        (f[2]),
        .lsu_wrb_address_i      (a[2]),
        .lsu_wrb_data_i         (d[2]),
        .lsu_wrb_ready_o        (rdy[2]),
        .fdivsqrt_wrb_valid_i   (v[3]),
        .fdivsqrt_wrb_address_i (a[3]),
        .fdivsqrt_wrb_data_i    (d[3]),
        .fdivsqrt_wrb_ready_o   (rdy[3]),
        .wr_first_valid_o       (w0_v),
        .wr_first_address_o     (w0_a),
        .wr_first_data_o        (w0_d),
        .wr_second_valid_o      (w1_v),
        .wr_second_address_o    (w1_a),
        .wr_second_data_o       (w1_d)
`ifdef FP_WRB_STALL_CNT_EN
        ,
        .stall_cnt_o            (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [NS-1:0] rdy;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    exp_t exp_q [$];
    ent_t mq [NS][$];
    int   rr;
    int   compared;
    int   mismatched;

    // Next-cycle stimulus, set by the caller before step()
    logic          nv [NS];
    logic          nf [NS];
    logic [AW-1:0] na [NS];
    logic [DW-1:0] nd [NS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_idle();
        for (int s = 0; s < NS; s++) begin
            nv[s] = 1'b0;
            nf[s] = 1'b1;
            na[s] = '0;
            nd[s] = '0;
        end
    endtask

    task automatic step();
        exp_t          e;
        int            g [$];
        logic [NS-1:0] r;
        int            busy;
        @(posedge clk);
        #1;
        busy = 0;
        for (int k = 0; k < NS; k++) begin
            int s;
            s = (rr + k) % NS;
            if (mq[s].size() != 0) begin
                busy++;
                if (g.size() < 2) g.push_back(s);
            end
        end
        for (int s = 0; s < NS; s++) r[s] = (mq[s].size() < DEPTH);
        e.v0 = 1'b0; e.a0 = '0; e.d0 = '0;
        e.v1 = 1'b0; e.a1 = '0; e.d1 = '0;
        if (g.size() > 0) begin
            e.v0 = 1'b1; e.a0 = mq[g[0]][0].a; e.d0 = mq[g[0]][0].d;
        end
        if (g.size() > 1) begin
            e.v1 = 1'b1; e.a1 = mq[g[1]][0].a; e.d1 = mq[g[1]][0].d;
        end
        e.rdy = r;
        exp_q.push_back(e);
`ifdef FP_WRB_STALL_CNT_EN
        if (busy > 2 && stall_model < 64'hFFFF_FFFF) stall_model++;
`endif
        for (int s = 0; s < NS; s++) begin
            v[s] = nv[s]; f[s] = nf[s]; a[s] = na[s]; d[s] = nd[s];
        end
        foreach (g[i]) void'(mq[g[i]].pop_front());
        if (g.size() > 0) rr = (g[g.size()-1] + 1) % NS;
        for (int s = 0; s < NS; s++) begin
            if (nv[s] && r[s] && (s == 3 || nf[s]) && na[s] != '0) begin
                ent_t en;
                en.a = na[s];
                en.d = nd[s];
                mq[s].push_back(en);
            end
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) mq[s].delete();
        rr = 0;
`ifdef FP_WRB_STALL_CNT_EN
        stall_model = 0;
`endif
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int s = 0; s < NS; s++) v[s] = 1'b0;
        #1;
        chk("rst_first_valid", 64'(w0_v), 64'd0);
        chk("rst_second_valid", 64'(w1_v), 64'd0);
        chk("rst_first_addr", 64'(w0_a), 64'd0);
        chk("rst_ready", 64'(rdy), 64'hF);
        model_clear();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the prediction for the current cycle mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("first_valid",  64'(w0_v), 64'(e.v0));
                chk("first_addr",   64'(w0_a), 64'(e.a0));
                chk("first_data",   w0_d,      e.d0);
                chk("second_valid", 64'(w1_v), 64'(e.v1));
                chk("second_addr",  64'(w1_a), 64'(e.a1));
                chk("second_data",  w1_d,      e.d1);
                chk("ready",        64'(rdy),  64'(e.rdy));
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        for (int s = 0; s < NS; s++) begin
            v[s] = 1'b0; f[s] = 1'b1; a[s] = '0; d[s] = '0;
        end
        model_clear();
        set_idle();
        #1;
        chk("reset_first_valid", 64'(w0_v), 64'd0);
        chk("reset_second_valid", 64'(w1_v), 64'd0);
        chk("reset_second_data", w1_d, 64'd0);
        chk("reset_ready", 64'(rdy), 64'hF);
        #7;
        rst_n = 1'b1;

        // Single write from falu1
        set_idle();
        nv[0] = 1'b1; na[0] = 6'd5; nd[0] = 64'hA;
        step();
        set_idle();
        repeat (2) step();

        // All four sources at once, addresses 1..4
        for (int s = 0; s < NS; s++) begin
            nv[s] = 1'b1; na[s] = AW'(s + 1); nd[s] = 64'h100 + 64'(s);
        end
        step();
        set_idle();
        repeat (3) step();

        // Discards: lsu integer result, falu2 to p0
        nv[2] = 1'b1; nf[2] = 1'b0; na[2] = 6'd7; nd[2] = 64'hDEAD;
        nv[1] = 1'b1; na[1] = 6'd0; nd[1] = 64'hBEEF;
        step();
        set_idle();
        repeat (2) step();

        // Backpressure: everyone valid for four cycles
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < NS; s++) begin
                nv[s] = 1'b1; na[s] = AW'(8 + 4 * c + s); nd[s] = {32'(c), 32'(s)};
            end
            step();
        end
        set_idle();
        repeat (6) step();

        // Fill the FIFOs, then reset mid-cycle
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < NS; s++) begin
                nv[s] = 1'b1; na[s] = AW'(40 + 4 * c + s); nd[s] = {$urandom, $urandom};
            end
            step();
        end
        async_reset();
        set_idle();
        repeat (3) step();

        // Randomised traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < NS; s++) begin
                nv[s] = ($urandom_range(0, 99) < 65);
                nf[s] = (s == 3) ? 1'b1 : ($urandom_range(0, 9) != 0);
                na[s] = ($urandom_range(0, 15) == 0) ? '0 : AW'($urandom_range(1, 63));
                nd[s] = {$urandom, $urandom};
            end
            step();
            if (n % 150 == 149) async_reset();
        end
        set_idle();
        repeat (6) step();
`ifdef FP_WRB_STALL_CNT_EN
        @(posedge clk);
        #1;
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
